multicycle_main_fsm: RTL and testbench
======================================

Name: multicycle_main_fsm

Overview:
- Main control FSM for the multicycle ARM-subset core. It drives the conditional-execution logic's request inputs (PCS, RegW, MemW, FlagW, NoWrite) and the datapath mux/enable selects.
- It sequences fetch, decode, execute, memory and writeback per instruction. It tolerates variable-latency memory through a MemReady handshake.
- It sits between the instruction register fields and the flag/condition gating stage, which masks its write requests with the condition result.

Parameters:
- ST_W, 4, width of the state register and of the debug state output.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous active-low reset; rst==0 forces FETCH immediately.
- Op  in  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal.
- Funct  in  6  Instr[25:20]: [5]=I immediate, [4:1]=cmd, [0]=S (DP) / L (memory).
- Rd  in  4  Instr[15:12]; Rd==15 marks a PC-writing writeback.
- MemReady  in  1  memory access completes this cycle.
- PCS  out  1  PC-write request (to condition gating).
- RegW  out  1  register-write request.
- MemW  out  1  memory-write request.
- FlagW  out  2  [1]=update N,Z; [0]=update C,V.
- NoWrite  out  1  suppress register write (CMP).
- NextPC  out  1  unconditional PC update (fetch increment).
- IRWrite  out  1  load instruction register.
- AdrSrc  out  1  0=PC, 1=ALU result as memory address.
- ResultSrc  out  2  00 ALUOut, 01 ReadData, 10 ALU direct.
- ALUSrcA  out  1  0=RD1, 1=PC.
- ALUSrcB  out  2  00 WriteData, 01 ExtImm, 10 constant 4.
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- ImmSrc  out  2  equals Op (combinational).
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01) (combinational).
- State  out  ST_W  current state encoding (debug/verification).

Behaviour:
- Moore FSM. All outputs except ImmSrc and RegSrc decode from the state register only. Unlisted outputs are 0 in each state.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5.
  - EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
  - Codes 10-15 go to FETCH next cycle with all outputs 0.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - IRWrite=NextPC=MemReady.
  - Stay while MemReady=0; otherwise -> DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - Op=00: Funct[5]=1 -> EXECI, else -> EXECR.
  - Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> FETCH (no side effect).
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00. Funct[0]=1 -> MEMRD, else -> MEMWR.
- MEMRD: AdrSrc=1. Stay until MemReady=1, then -> MEMWB.
- MEMWB: ResultSrc=01, RegW=1, PCS=(Rd==15) -> FETCH.
- MEMWR: AdrSrc=1, MemW=1. MemW is held every cycle until MemReady=1, then -> FETCH.
- EXECR/EXECI: ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 (EXECI); -> ALUWB.
- ALU decode, active in EXECR/EXECI only:
  - Funct[4:1]=0100 -> 00 ADD; 0010 -> 01 SUB; 0000 -> 10 AND; 1100 -> 11 ORR.
  - 1010 -> 01 SUB with NoWrite=1 (CMP).
  - Any other cmd -> 00 with NoWrite=1.
  - FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & cmd in {ADD, SUB, CMP}.
  - CMP with S=0 still raises NoWrite and leaves FlagW=00.
- ALUWB: ResultSrc=00, RegW=1. PCS=(Rd==15). NoWrite is re-driven from the cmd decode, so CMP writes nothing. -> FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALUControl=00, PCS=1 -> FETCH.
- Latency (MemReady tied 1): DP=4 cycles, load=5, store=4, branch=3.
- Reset mid-operation: the state returns to FETCH asynchronously and the outputs take FETCH values immediately. With MemReady=0 the reset outputs are all 0 except ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- Op/Funct/Rd are sampled only in DECODE, EXECR/EXECI, MEMADR, ALUWB and MEMWB. The instruction register holds them stable from FETCH completion onward.

Test Plan:
- Reset: rst=0 during MEMWR with MemW=1 -> same-cycle State=0, MemW=0. After release with MemReady=1: IRWrite=1, NextPC=1, then DECODE.
- ADDS, register form (Op=00, Funct=001001, Rd=3, MemReady=1):
  - State sequence 0,1,6,8,0.
  - In EXECR: ALUControl=00, FlagW=11.
  - In ALUWB: RegW=1, PCS=0.
- CMP immediate (Funct=110101):
  - State sequence 0,1,7,8.
  - ALUControl=01, FlagW=11, NoWrite=1 in EXECI and ALUWB.
- Load with stalls (Op=01, Funct[0]=1, Rd=15, MemReady low 3 cycles in MEMRD):
  - MEMRD held 4 cycles with AdrSrc=1.
  - MEMWB has RegW=1, ResultSrc=01, PCS=1.
- Store with stall (Op=01, Funct[0]=0, MemReady=0 for 2 cycles): MemW=1 for 3 consecutive cycles, then FETCH.
- Branch and illegal op:
  - Op=10 -> BRANCH with PCS=1, ResultSrc=10, 3-cycle instruction.
  - Op=11 -> DECODE then FETCH with no RegW/MemW/PCS pulse.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle ARM-subset core.
// Sequences fetch / decode / execute / memory / writeback for each instruction,
// waits on MemReady for variable-latency memory, and raises the write requests
// that the condition-gating stage later masks with the condition result.
module multicycle_main_fsm #(
  parameter int ST_W = 4
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic [1:0]      Op,
  input  logic [5:0]      Funct,
  input  logic [3:0]      Rd,
  input  logic            MemReady,
  output logic            PCS,
  output logic            RegW,
  output logic            MemW,
  output logic [1:0]      FlagW,
  output logic            NoWrite,
  output logic            NextPC,
  output logic            IRWrite,
  output logic            AdrSrc,
  output logic [1:0]      ResultSrc,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUControl,
  output logic [1:0]      ImmSrc,
  output logic [1:0]      RegSrc,
  output logic [ST_W-1:0] State
);

  typedef enum logic [ST_W-1:0] {
    FETCH  = ST_W'(0),
    DECODE = ST_W'(1),
    MEMADR = ST_W'(2),
    MEMRD  = ST_W'(3),
    MEMWB  = ST_W'(4),
    MEMWR  = ST_W'(5),
    EXECR  = ST_W'(6),
    EXECI  = ST_W'(7),
    ALUWB  = ST_W'(8),
    BRANCH = ST_W'(9)
  } state_e;

  state_e     state_q;
  state_e     state_d;

  logic [3:0] cmd;
  logic [1:0] cmdAluCtl;
  logic       cmdNoWrite;
  logic [1:0] cmdFlagW;
  logic       pcWriteback;

  assign cmd         = Funct[4:1];
  assign pcWriteback = (Rd == 4'd15);

  // Immediate and register-source selects follow the opcode directly, independent of state.
  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};
  assign State  = state_q;

  // State register; reset drops straight back to FETCH without waiting for a clock edge.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Data-processing cmd decode: ALU operation, register-write suppression and flag-update mask.
  always_comb begin
    cmdAluCtl  = 2'b00;
    cmdNoWrite = 1'b0;
    unique case (cmd)
      4'b0100: cmdAluCtl = 2'b00;
      4'b0010: cmdAluCtl = 2'b01;
      4'b0000: cmdAluCtl = 2'b10;
      4'b1100: cmdAluCtl = 2'b11;
      4'b1010: begin
        cmdAluCtl  = 2'b01;
        cmdNoWrite = 1'b1;
      end
      default: begin
        cmdAluCtl  = 2'b00;
        cmdNoWrite = 1'b1;
      end
    endcase
    cmdFlagW[1] = Funct[0];
    cmdFlagW[0] = Funct[0] & ((cmd == 4'b0100) | (cmd == 4'b0010) | (cmd == 4'b1010));
  end

  // Next-state and per-state control outputs; anything not set in a state stays 0.
  always_comb begin
    state_d    = FETCH;
    PCS        = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    FlagW      = 2'b00;
    NoWrite    = 1'b0;
    NextPC     = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    case (state_q)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        NextPC    = MemReady;
        state_d   = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        unique case (Op)
          2'b00:   state_d = Funct[5] ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        PCS       = pcWriteback;
        state_d   = FETCH;
      end
      MEMWR: begin
        AdrSrc  = 1'b1;
        MemW    = 1'b1;
        state_d = MemReady ? FETCH : MEMWR;
      end
      EXECR: begin
        ALUSrcB    = 2'b00;
        ALUControl = cmdAluCtl;
        NoWrite    = cmdNoWrite;
        FlagW      = cmdFlagW;
        state_d    = ALUWB;
      end
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = cmdAluCtl;
        NoWrite    = cmdNoWrite;
        FlagW      = cmdFlagW;
        state_d    = ALUWB;
      end
      ALUWB: begin
        ResultSrc = 2'b00;
        RegW      = 1'b1;
        PCS       = pcWriteback;
        NoWrite   = cmdNoWrite;
        state_d   = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCS       = 1'b1;
        state_d   = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: directed scenarios plus random
// instructions, each turned into an expected per-cycle trace by an
// instruction-level model and compared against the DUT every cycle.
module tb_multicycle_main_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcs;
    logic       regW;
    logic       memW;
    logic [1:0] flagW;
    logic       noWrite;
    logic       nextPC;
    logic       irWrite;
    logic       adrSrc;
    logic [1:0] resultSrc;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluControl;
  } outRec;

  logic       CLK;
  logic       rst;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       MemReady;
  logic       PCS, RegW, MemW, NoWrite, NextPC, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0] State;

  int total = 0;
  int bad   = 0;

  outRec expQ[$];
  logic  mrQ[$];

  multicycle_main_fsm #(.ST_W(4)) dut (
    .CLK(CLK), .rst(rst), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .FlagW(FlagW), .NoWrite(NoWrite),
    .NextPC(NextPC), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .State(State)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic outRec observed();
    outRec o;
    o.st = State; o.pcs = PCS; o.regW = RegW; o.memW = MemW; o.flagW = FlagW;
    o.noWrite = NoWrite; o.nextPC = NextPC; o.irWrite = IRWrite; o.adrSrc = AdrSrc;
    o.resultSrc = ResultSrc; o.aluSrcA = ALUSrcA; o.aluSrcB = ALUSrcB;
    o.aluControl = ALUControl;
    return o;
  endfunction

  // Expected record for an instruction-fetch cycle (PC increment datapath).
  function automatic outRec fetchRec(input logic mr);
    outRec r = '0;
    r.aluSrcA = 1'b1; r.aluSrcB = 2'b10; r.resultSrc = 2'b10;
    r.irWrite = mr; r.nextPC = mr;
    return r;
  endfunction

  // Data-processing semantics taken from the instruction fields.
  function automatic void aluModel(input logic [5:0] f, output logic [1:0] ctl,
                                   output logic nw, output logic [1:0] fw);
    logic [3:0] c;
    logic       flagsCV;
    c = f[4:1];
    nw = 1'b0;
    flagsCV = 1'b0;
    if (c == 4'd4)       begin ctl = 2'd0; flagsCV = 1'b1; end
    else if (c == 4'd2)  begin ctl = 2'd1; flagsCV = 1'b1; end
    else if (c == 4'd0)  begin ctl = 2'd2; end
    else if (c == 4'd12) begin ctl = 2'd3; end
    else if (c == 4'd10) begin ctl = 2'd1; nw = 1'b1; flagsCV = 1'b1; end
    else                 begin ctl = 2'd0; nw = 1'b1; end
    fw = {f[0], f[0] & flagsCV};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obsV, input logic [31:0] expV);
    total++;
    assert (obsV === expV)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obsV, expV);
    end
  endtask

  task automatic stepClock();
    @(posedge CLK);
    #1;
  endtask

  // Builds the expected trace of one instruction from its class and stall plan.
  task automatic buildTrace(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                            input int fetchStall, input int memStall);
    outRec r;
    logic [1:0] ctl, fw;
    logic nw;
    for (int i = 0; i < fetchStall; i++) begin
      expQ.push_back(fetchRec(1'b0)); mrQ.push_back(1'b0);
    end
    expQ.push_back(fetchRec(1'b1)); mrQ.push_back(1'b1);
    r = fetchRec(1'b0); r.st = 4'd1;
    expQ.push_back(r); mrQ.push_back(1'($urandom));
    if (op == 2'b00) begin
      aluModel(f, ctl, nw, fw);
      r = '0; r.st = f[5] ? 4'd7 : 4'd6; r.aluSrcB = f[5] ? 2'b01 : 2'b00;
      r.aluControl = ctl; r.noWrite = nw; r.flagW = fw;
      expQ.push_back(r); mrQ.push_back(1'($urandom));
      r = '0; r.st = 4'd8; r.regW = 1'b1; r.pcs = (rd == 4'd15); r.noWrite = nw;
      expQ.push_back(r); mrQ.push_back(1'($urandom));
    end else if (op == 2'b01) begin
      r = '0; r.st = 4'd2; r.aluSrcB = 2'b01;
      expQ.push_back(r); mrQ.push_back(1'($urandom));
      r = '0; r.st = f[0] ? 4'd3 : 4'd5; r.adrSrc = 1'b1; r.memW = ~f[0];
      for (int i = 0; i <= memStall; i++) begin
        expQ.push_back(r); mrQ.push_back(i == memStall);
      end
      if (f[0]) begin
        r = '0; r.st = 4'd4; r.resultSrc = 2'b01; r.regW = 1'b1; r.pcs = (rd == 4'd15);
        expQ.push_back(r); mrQ.push_back(1'($urandom));
      end
    end else if (op == 2'b10) begin
      r = '0; r.st = 4'd9; r.aluSrcB = 2'b01; r.resultSrc = 2'b10; r.pcs = 1'b1;
      expQ.push_back(r); mrQ.push_back(1'($urandom));
    end
  endtask

  // Drives one instruction through the DUT and checks every cycle of its trace.
  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [5:0] f,
                               input logic [3:0] rd, input int fetchStall, input int memStall);
    outRec e;
    int cyc;
    Op = op; Funct = f; Rd = rd;
    expQ.delete(); mrQ.delete();
    buildTrace(op, f, rd, fetchStall, memStall);
    checkOutput({name, ".len"}, 32'(expQ.size()),
                32'(2 + fetchStall + ((op == 2'b00) ? 2 : (op == 2'b10) ? 1 :
                    (op == 2'b01) ? (2 + memStall + (f[0] ? 1 : 0)) : 0)));
    cyc = 0;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      MemReady = mrQ.pop_front();
      #2;
      if (cyc == 0) begin
        checkOutput({name, ".ImmSrc"}, 32'(ImmSrc), 32'(op));
        checkOutput({name, ".RegSrc"}, 32'(RegSrc), 32'({op == 2'b01, op == 2'b10}));
      end
      checkOutput($sformatf("%s.c%0d", name, cyc), 32'(observed()), 32'(e));
      stepClock();
      cyc++;
    end
  endtask

  initial begin
    outRec e;
    rst = 1'b0; MemReady = 1'b0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
    #2;
    checkOutput("reset.out", 32'(observed()), 32'(fetchRec(1'b0)));
    @(posedge CLK);
    #1;
    rst = 1'b1;
    $display("[TB] reset released");

    // Asynchronous reset while a store is holding MemW.
    Op = 2'b01; Funct = 6'b000000; Rd = 4'd0; MemReady = 1'b1;
    stepClock(); stepClock(); stepClock();
    MemReady = 1'b0;
    #2;
    checkOutput("rstmid.state", 32'(State), 32'd5);
    checkOutput("rstmid.memw", 32'(MemW), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("rstmid.stateNow", 32'(State), 32'd0);
    checkOutput("rstmid.memwNow", 32'(MemW), 32'd0);
    checkOutput("rstmid.out", 32'(observed()), 32'(fetchRec(1'b0)));
    rst = 1'b1; MemReady = 1'b1;
    #1;
    e = fetchRec(1'b1);
    checkOutput("rstrel.out", 32'(observed()), 32'(e));
    @(posedge CLK);
    #2;
    checkOutput("rstrel.decode", 32'(State), 32'd1);
    rst = 1'b0;
    #1;
    rst = 1'b1; MemReady = 1'b0;
    stepClock();

    // Directed instructions.
    applyStimulus("adds",   2'b00, 6'b001001, 4'd3,  0, 0);
    applyStimulus("cmpi",   2'b00, 6'b110101, 4'd0,  0, 0);
    applyStimulus("cmpNoS", 2'b00, 6'b010100, 4'd1,  0, 0);
    applyStimulus("orrPc",  2'b00, 6'b011000, 4'd15, 1, 0);
    applyStimulus("ldr",    2'b01, 6'b011001, 4'd15, 0, 3);
    applyStimulus("str",    2'b01, 6'b011000, 4'd2,  0, 2);
    applyStimulus("ldrFast",2'b01, 6'b000001, 4'd4,  0, 0);
    applyStimulus("b",      2'b10, 6'b000000, 4'd0,  0, 0);
    applyStimulus("illegal",2'b11, 6'b111111, 4'd15, 0, 0);
    applyStimulus("after",  2'b10, 6'b101010, 4'd7,  2, 0);
    $display("[TB] directed steps complete");

    // Random instructions, biased toward the recognised cmd encodings.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] rd;
      int sel;
      op = 2'($urandom_range(0, 3));
      f = 6'($urandom);
      sel = $urandom_range(0, 5);
      case (sel)
        0: f[4:1] = 4'd4;
        1: f[4:1] = 4'd2;
        2: f[4:1] = 4'd0;
        3: f[4:1] = 4'd12;
        4: f[4:1] = 4'd10;
        default: ;
      endcase
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      applyStimulus($sformatf("rnd%0d", n), op, f, rd, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    MemReady = 1'b0;
    #2;
    checkOutput("final.state", 32'(State), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
